noc_rr_arbiter: RTL
===================

NOC_RR_ARBITER -- requirements
Module: noc_rr_arbiter

Interface
REQ-001 Parameter NUM_SRC, default 4, number of requesting packet sources.
REQ-002 Parameter PKT_W, default 13, packet width: [1:0] dest_address, [3:2] packet_type, [11:4] payload, [12] end_of_packet.
REQ-003 Parameter MAX_BEATS, default 16, maximum beats per packet before forced release.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 src_packet  input  NUM_SRC*PKT_W  source packets; source i occupies bits [i*PKT_W +: PKT_W].
REQ-007 src_valid  input  NUM_SRC  per-source valid.
REQ-008 src_ready  output  NUM_SRC  per-source ready.
REQ-009 dst_packet  output  PKT_W  packet toward the NoC storage path.
REQ-010 dst_valid  output  1  output valid.
REQ-011 dst_ready  input  1  NoC ready.
REQ-012 grant  output  NUM_SRC  one-hot current owner; all-zero when idle.
REQ-013 busy  output  1  high while a source owns the output.
REQ-014 err_long_pkt  output  1  one-cycle pulse on forced release.

Function
REQ-015 FSM SHALL have two states: IDLE, LOCKED.
REQ-016 IDLE: grant=0, busy=0, dst_valid=0, src_ready=0, dst_packet=0.
REQ-017 IDLE with any src_valid high: next cycle grant SHALL hold the winner, state LOCKED, beat counter cleared.
REQ-018 Winner = first valid source searching upward, with wrap-around, from last_grant+1 modulo NUM_SRC.
REQ-019 LOCKED with owner g: dst_packet=src_packet[g], dst_valid=src_valid[g], src_ready[g]=dst_ready, all other src_ready=0; these paths are combinational.
REQ-020 Transfer = dst_valid && dst_ready; the beat counter increments by 1 per transfer and is held otherwise.
REQ-021 Owner dropping src_valid mid-packet SHALL NOT release grant.
REQ-022 Transfer with dst_packet[12]=1: next cycle state IDLE, last_grant<=g, grant<=0.
REQ-023 Transfer that is beat number MAX_BEATS with dst_packet[12]=0: that transfer completes; next cycle state IDLE, last_grant<=g, err_long_pkt=1 for exactly that one cycle.
REQ-024 Beat counter width SHALL be clog2(MAX_BEATS+1) and SHALL never wrap.
REQ-025 Single-beat packet (EOP on first beat) releases after one transfer.
REQ-026 Back-to-back packets SHALL incur exactly one IDLE bubble cycle between the EOP transfer and the next grant.
REQ-027 Arbitration latency: first beat transferable no earlier than 1 cycle after src_valid is seen in IDLE.
REQ-028 No packet content is modified; dest_address and packet_type pass unchanged.

Reset
REQ-029 Reset asserted at any time, including mid-packet, SHALL immediately force state IDLE, grant=0, busy=0, dst_valid=0, src_ready=0, dst_packet=0, err_long_pkt=0, beat counter=0.
REQ-030 Reset SHALL set last_grant=NUM_SRC-1 so that source 0 has first priority after reset.
REQ-031 A partially transferred packet is discarded by reset; no resume.

Verification
REQ-032 After reset, src_valid=4'b1111, all packets single-beat EOP=1, dst_ready=1 -> grants 0,1,2,3,0 in order, one bubble cycle between each.
REQ-033 Src1 sends a 3-beat packet (EOP on beat 3) while src0 valid; dst_ready=1 -> src0 ready=0 throughout; grant=4'b0010 for 3 beats; then grant=4'b0001.
REQ-034 Owner asserts dst_valid with dst_ready low for 5 cycles -> dst_packet stable, no transfer, counter unchanged, grant held.
REQ-035 Src2 sends 16 beats with EOP=0 (MAX_BEATS=16) -> err_long_pkt=1 for one cycle after beat 16; state IDLE; next grant from src3 upward.
REQ-036 Reset asserted after beat 2 of a 4-beat packet -> all outputs 0 the same cycle; after release, src0 wins if valid.
REQ-037 Owner deasserts src_valid for 3 cycles mid-packet, src3 valid -> grant unchanged, dst_valid=0 during the gap, packet resumes and completes.

Source files
------------

// File: rtl/noc_rr_arbiter.sv
// Round-robin packet arbiter: locks the output to one source for a whole packet,
// releasing on end-of-packet or after MAX_BEATS transfers (flagged as an error).
module noc_rr_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int PKT_W     = 13,
  parameter int MAX_BEATS = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*PKT_W-1:0] src_packet,
  input  logic [NUM_SRC-1:0]       src_valid,
  output logic [NUM_SRC-1:0]       src_ready,
  output logic [PKT_W-1:0]         dst_packet,
  output logic                     dst_valid,
  input  logic                     dst_ready,
  output logic [NUM_SRC-1:0]       grant,
  output logic                     busy,
  output logic                     err_long_pkt
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  localparam logic [CNT_W-1:0] BEAT_LIMIT = CNT_W'(MAX_BEATS);
  localparam logic [CNT_W-1:0] BEAT_ONE   = CNT_W'(1);
  localparam logic [IDX_W:0]   SRC_COUNT  = (IDX_W + 1)'(NUM_SRC);
  localparam logic [IDX_W-1:0] LAST_SRC   = IDX_W'(NUM_SRC - 1);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;

  logic [0:0]         r_state;
  logic [IDX_W-1:0]   r_owner;
  logic [IDX_W-1:0]   r_last_grant;
  logic [NUM_SRC-1:0] r_grant;
  logic [CNT_W-1:0]   r_beat_cnt;
  logic               r_err;

  logic [PKT_W-1:0]   w_pkt [NUM_SRC];
  logic               w_locked;
  logic               w_any_req;
  logic               w_xfer;
  logic               w_eop;
  logic               w_last_beat;
  logic [IDX_W-1:0]   w_winner;
  logic [CNT_W-1:0]   w_cnt_inc;

  // Search starts one past the previous owner so every source gets a turn.
  function automatic logic [IDX_W-1:0] f_rr_pick(
    input logic [NUM_SRC-1:0] req,
    input logic [IDX_W-1:0]   last
  );
    logic [IDX_W-1:0] pick;
    logic [IDX_W:0]   sum;
    logic             found;
    pick  = '0;
    found = 1'b0;
    for (int off = 1; off <= NUM_SRC; off++) begin
      sum = {1'b0, last} + (IDX_W + 1)'(off);
      if (sum >= SRC_COUNT) begin
        sum = sum - SRC_COUNT;
      end
      if (!found && req[sum[IDX_W-1:0]]) begin
        pick  = sum[IDX_W-1:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [NUM_SRC-1:0] f_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SRC-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
    assign w_pkt[gi] = src_packet[gi*PKT_W +: PKT_W];
  end

  assign w_locked  = (r_state == S_LOCKED);
  assign w_any_req = |src_valid;
  assign w_winner  = f_rr_pick(src_valid, r_last_grant);

  // The owner's handshake is passed straight through, so no beat is buffered here.
  assign dst_packet = w_locked ? w_pkt[r_owner] : '0;
  assign dst_valid  = w_locked & src_valid[r_owner];
  assign src_ready  = w_locked ? (r_grant & {NUM_SRC{dst_ready}}) : '0;

  assign w_xfer      = dst_valid & dst_ready;
  assign w_eop       = dst_packet[PKT_W-1];
  assign w_cnt_inc   = r_beat_cnt + BEAT_ONE;
  assign w_last_beat = (w_cnt_inc == BEAT_LIMIT);

  assign grant        = r_grant;
  assign busy         = w_locked;
  assign err_long_pkt = r_err;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_owner      <= '0;
      r_last_grant <= LAST_SRC;
      r_grant      <= '0;
      r_beat_cnt   <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state    <= S_LOCKED;
            r_owner    <= w_winner;
            r_grant    <= f_onehot(w_winner);
            r_beat_cnt <= '0;
          end
        end
        default: begin
          if (w_xfer) begin
            // Release on end-of-packet, or force it once the beat limit is reached.
            if (w_eop || w_last_beat) begin
              r_state      <= S_IDLE;
              r_grant      <= '0;
              r_last_grant <= r_owner;
              r_beat_cnt   <= '0;
              r_err        <= ~w_eop;
            end else begin
              r_beat_cnt <= w_cnt_inc;
            end
          end
        end
      endcase
    end
  end

endmodule
